// File: rtl/spi_frame_master_if.sv
// Host-side bundle for spi_frame_master: start/busy/done handshake, frame words and the SPI pins.
// The master modport is the initiator's view. The slave modport is the view of the host and SPI target.
interface spi_frame_master_if #(
  parameter int FRAME_BITS = 28
);
  logic                  start;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  busy;
  logic                  done;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  sclk;
  logic                  csn;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, csn, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, csn, mosi
  );
endinterface

// File: rtl/spi_frame_master.sv
// SPI mode-0 initiator: shifts one FRAME_BITS command word out MSB first and captures the same number of miso bits.
// sclk, csn and mosi come straight from flops; each sclk half-period lasts CLK_DIV clk cycles.
module spi_frame_master #(
  parameter int FRAME_BITS = 28,
  parameter int CLK_DIV    = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_frame_master_if.master  bus
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  csn_q, csn_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  div_last_s;

  assign div_last_s = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    csn_d      = csn_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.tx_data;
          mosi_d  = bus.tx_data[FRAME_BITS-1];
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end

      SETUP: begin
        if (div_last_s) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      // miso is captured at the end of the high phase, before the next falling-edge launch.
      HIGH: begin
        if (div_last_s) begin
          div_d      = '0;
          sclk_d     = 1'b0;
          rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], bus.miso};
          bit_d      = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            mosi_d  = shift_q[FRAME_BITS-2];
            state_d = LOW;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      LOW: begin
        if (div_last_s) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (div_last_s) begin
          div_d     = '0;
          csn_d     = 1'b1;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          state_d   = GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      // A start on the gap's last cycle chains straight into the next frame, so csn stays high for only CLK_DIV cycles.
      GAP: begin
        if (div_last_s) begin
          div_d = '0;
          if (bus.start) begin
            shift_d = bus.tx_data;
            mosi_d  = bus.tx_data[FRAME_BITS-1];
            csn_d   = 1'b0;
            bit_d   = '0;
            state_d = SETUP;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
        csn_d   = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.sclk    = sclk_q;
  assign bus.csn     = csn_q;
  assign bus.mosi    = mosi_q;

endmodule
